// File: rtl/vga_fb_pkg.sv
// Shared types and default sizing for the VGA framebuffer arbiter.
package vga_fb_pkg;

  localparam int FB_PIXELS_DEF  = 12288;
  localparam int ADDR_W_DEF     = 14;
  localparam int PIX_W_DEF      = 3;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int LOW_WM_DEF     = 2;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE
  } fb_arb_state_t;

endpackage

// File: rtl/vga_pixel_fifo.sv
// Synchronous pixel FIFO with occupancy count and single-cycle flush.
module vga_pixel_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count_q != '0);

  // NOTE: the storage array has no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares one single-port framebuffer RAM between scanout prefetch and a host writer.
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int FB_PIXELS  = FB_PIXELS_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int PIX_W      = PIX_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int LOW_WM     = LOW_WM_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              pix_pop,
  output logic              pix_valid,
  output logic [PIX_W-1:0]  pix_data,
  output logic              underrun,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic [PIX_W-1:0]  mem_rdata
);

  localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_PIXELS - 1);

  fb_arb_state_t     state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              inflight_q;
  logic              underrun_q, underrun_d;
  logic [CNT_W-1:0]  fifo_count, credits;
  logic              fifo_empty, rd_eligible, rd_grant, wr_grant;

  assign fifo_empty = (fifo_count == '0);
  assign credits    = fifo_count + CNT_W'(inflight_q);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    rd_grant    = 1'b0;
    wr_grant    = 1'b0;
    rd_eligible = (state_q == FETCH) && !frame_start && (credits < CNT_W'(FIFO_DEPTH));

    if (rd_eligible && (credits < CNT_W'(LOW_WM))) rd_grant = 1'b1;
    else if (wr_valid)                             wr_grant = 1'b1;
    else if (rd_eligible)                          rd_grant = 1'b1;

    // Address counter parks on the last pixel; DONE blocks any further read.
    if (rd_grant) begin
      if (rd_addr_q == LAST_ADDR) state_d   = DONE;
      else                        rd_addr_d = rd_addr_q + ADDR_W'(1);
    end

    if (frame_start) begin
      state_d   = FETCH;
      rd_addr_d = '0;
    end

    underrun_d = frame_start ? 1'b0 : (underrun_q || (pix_pop && fifo_empty));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_addr_q  <= '0;
      inflight_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      inflight_q <= rd_grant;
      underrun_q <= underrun_d;
    end
  end

  // frame_start flushes the FIFO, which also discards a returning read.
  vga_pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIX_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (frame_start),
    .push      (inflight_q),
    .push_data (mem_rdata),
    .pop       (pix_pop),
    .head      (pix_data),
    .count     (fifo_count)
  );

  assign pix_valid = !fifo_empty;
  assign underrun  = underrun_q;
  assign wr_ready  = wr_grant;
  assign mem_we    = wr_grant;
  assign mem_wdata = wr_grant ? wr_data : '0;
  assign mem_addr  = rd_grant ? rd_addr_q : (wr_grant ? wr_addr : '0);

endmodule
